// File: rtl/rs_bram_fifo_rd_ctrl.sv
// Read-side controller for a BRAM-backed FIFO: fetches words ahead of the consumer into a
// 2-entry buffer so the 1-cycle BRAM latency is hidden and a 1 word/clk stream is sustained.
module rs_bram_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  lreset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0]   fptr;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic [2:0]            pending;

  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid & m_ready;
  // Words that will occupy the buffer after this edge if no new fetch is issued.
  assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign ram_ren  = !lreset && !flush && (fptr != wr_ptr) && (pending < 3'd2);
  assign ram_addr = fptr[ADDR_WIDTH-1:0];
  assign m_data   = head_q;
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);

  always_ff @(posedge clk) begin
    if (lreset) begin
      fptr     <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (flush) begin
      // Dropping inflight discards the data of any read issued before the flush.
      fptr     <= wr_ptr;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= ram_ren;
      if (ram_ren) fptr <= fptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({pop, inflight})
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= ram_rdata;
          end else begin
            head_q <= tail_q;
            tail_q <= ram_rdata;
          end
        end
        2'b10: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) head_q <= ram_rdata;
          else             tail_q <= ram_rdata;
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bram_fifo_rd_ctrl.sv
// Bench for rs_bram_fifo_rd_ctrl (ADDR_WIDTH=4): BRAM and writer models, a queue-based
// reference of the FIFO contents, directed corner sequences, a pointer table and a random run.
module tb_rs_bram_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          lreset = 1'b1;
  logic [AW:0]   wr_ptr = '0;
  logic          flush = 1'b0;
  logic          ram_ren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          empty;

  rs_bram_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .lreset(lreset), .wr_ptr(wr_ptr), .flush(flush),
    .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_ptr(rd_ptr), .level(level), .empty(empty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  // Read data only meaningful the cycle after ram_ren; garbage otherwise.
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_addr];
    else         ram_rdata <= DW'($urandom);
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: words the writer has committed but the consumer has not yet taken.
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   model_rd = '0;
  logic [AW-1:0] addr_log[$];
  bit            mon_en = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [AW:0] exp_lvl;
      exp_lvl = wr_ptr - model_rd;
      chk("level", 32'(level), 32'(exp_lvl));
      chk("rd_ptr", 32'(rd_ptr), 32'(model_rd));
      chk("empty", 32'(empty), 32'(exp_lvl == 0));
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (lreset || flush) chk("ren_blocked", 32'(ram_ren), 32'd0);
      if (ram_ren) addr_log.push_back(ram_addr);
      if (lreset) begin
        exp_q.delete();
        model_rd = '0;
      end else if (flush) begin
        exp_q.delete();
        model_rd = wr_ptr;
      end else if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_beat", 32'(m_data), 32'hFFFFFFFF);
        else chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        model_rd = model_rd + 1'b1;
      end
      prev_hold = m_valid && !m_ready && !lreset && !flush;
      prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    logic [AW:0] lvl;
    mem[wr_ptr[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_ptr = wr_ptr + 1'b1;
    lvl = wr_ptr - model_rd;
    assert (lvl <= 16) else $error("writer overran FIFO depth");
  endtask

  task automatic do_reset();
    lreset = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0;
    tick(); tick();
    lreset = 1'b0;
    exp_q.delete();
    model_rd = '0;
  endtask

  task automatic wait_drain(input int bound, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin tick(); n++; end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [AW:0] rd_start;
    logic [AW:0] wr_end;
    logic [AW:0] exp_level;
  } ptr_vec_t;

  ptr_vec_t vecs[5];

  initial begin
    logic [13:0] ren_hist, beat_hist;
    int          cnt;
    logic [DW-1:0] w0;

    vecs[0] = '{5'h0E, 5'h12, 5'd4};
    vecs[1] = '{5'h1E, 5'h02, 5'd4};
    vecs[2] = '{5'h00, 5'h10, 5'd16};
    vecs[3] = '{5'h0F, 5'h11, 5'd2};
    vecs[4] = '{5'h13, 5'h13, 5'd0};

    // 1: reset values, then idle with nothing written
    lreset = 1'b1; wr_ptr = '0;
    tick();
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_ram_ren", 32'(ram_ren), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    tick();
    lreset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_m_valid", 32'(m_valid), 0);
      chk("idle_ram_ren", 32'(ram_ren), 0);
      chk("idle_empty", 32'(empty), 1);
      chk("idle_level", 32'(level), 0);
      tick();
    end

    // 2: single word latency
    do_reset();
    m_ready = 1'b1;
    write_word(18'h2A5A5);
    @(negedge clk);
    chk("lat_ren_c0", 32'(ram_ren), 1);
    chk("lat_addr_c0", 32'(ram_addr), 0);
    chk("lat_valid_c0", 32'(m_valid), 0);
    tick(); @(negedge clk);
    chk("lat_valid_c1", 32'(m_valid), 0);
    tick(); @(negedge clk);
    chk("lat_valid_c2", 32'(m_valid), 1);
    chk("lat_data_c2", 32'(m_data), 32'h2A5A5);
    tick(); @(negedge clk);
    chk("lat_rd_ptr", 32'(rd_ptr), 1);
    chk("lat_empty", 32'(empty), 1);
    tick();

    // 3: eight words streamed with m_ready=1 -> no bubbles
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) write_word(DW'(18'h10000 + i * 7));
      @(negedge clk);
      ren_hist[i]  = ram_ren;
      beat_hist[i] = m_valid & m_ready;
      tick();
    end
    chk("stream_ren_pattern", 32'(ren_hist), 32'h00FF);
    chk("stream_beat_pattern", 32'(beat_hist), 32'h03FC);

    // 4: backpressure: only two fetches, head stable, then full release
    do_reset();
    m_ready = 1'b0;
    cnt = 0;
    w0 = 18'h3C001;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) write_word(w0 + DW'(i));
      @(negedge clk);
      cnt += int'(ram_ren);
      tick();
    end
    chk("bp_ren_count", 32'(cnt), 2);
    @(negedge clk);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'(m_data), 32'(w0));
    tick();
    m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(m_valid & m_ready);
      tick();
    end
    chk("bp_beats", 32'(cnt), 4);
    wait_drain(4, "bp_drain");

    // 5: pointer wrap table (flush used to seed the pointers)
    for (int v = 0; v < 5; v++) begin
      logic [AW:0] n;
      m_ready = 1'b0;
      addr_log.delete();
      flush = 1'b1;
      wr_ptr = vecs[v].rd_start;
      tick();
      flush = 1'b0;
      n = vecs[v].wr_end - vecs[v].rd_start;
      for (int k = 0; k < int'(n); k++) begin
        write_word(DW'(18'h20000 + v * 64 + k));
        tick();
      end
      repeat (3) tick();
      @(negedge clk);
      chk("tbl_level", 32'(level), 32'(vecs[v].exp_level));
      chk("tbl_rd_start", 32'(rd_ptr), 32'(vecs[v].rd_start));
      tick();
      m_ready = 1'b1;
      wait_drain(40, "tbl_drain");
      tick();
      @(negedge clk);
      chk("tbl_rd_end", 32'(rd_ptr), 32'(vecs[v].wr_end));
      chk("tbl_addr_count", 32'(addr_log.size()), 32'(n));
      for (int k = 0; k < addr_log.size(); k++) begin
        logic [AW:0] a;
        a = vecs[v].rd_start + AW'(k);
        chk("tbl_addr", 32'(addr_log[k]), 32'(a[AW-1:0]));
      end
      tick();
    end

    // 6a: flush while one word is buffered and a read is in flight
    do_reset();
    m_ready = 1'b0;
    write_word(18'h11111); tick();
    write_word(18'h22222); tick();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_valid", 32'(m_valid), 1);
    chk("fl_pre_ren", 32'(ram_ren), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", 32'(m_valid), 0);
    chk("fl_rd_ptr", 32'(rd_ptr), 2);
    chk("fl_ren", 32'(ram_ren), 0);
    tick();
    m_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("fl_no_stale", 32'(m_valid), 0);
    tick();

    // 6b: reset in the middle of a stream
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin write_word(DW'(18'h05000 + i)); tick(); end
    lreset = 1'b1;
    @(negedge clk);
    chk("mr_ren", 32'(ram_ren), 0);
    tick();
    @(negedge clk);
    chk("mr_rd_ptr", 32'(rd_ptr), 0);
    chk("mr_valid", 32'(m_valid), 0);
    chk("mr_data", 32'(m_data), 0);
    chk("mr_level", 32'(level), 5);
    tick();
    lreset = 1'b0;
    wr_ptr = '0;
    repeat (6) tick();
    @(negedge clk);
    chk("mr_no_stale", 32'(m_valid), 0);
    tick();

    // Random traffic with occasional flush and reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [AW:0] lvl;
      m_ready = ($urandom_range(0, 3) != 0);
      if (lreset) begin
        lreset = 1'b0;
        flush = 1'b0;
        wr_ptr = '0;
      end else begin
        flush = ($urandom_range(0, 99) == 0);
        lreset = !flush && ($urandom_range(0, 299) == 0);
        lvl = wr_ptr - model_rd;
        if (!lreset && lvl < 16 && $urandom_range(0, 2) != 0)
          write_word(DW'($urandom));
      end
      tick();
    end
    lreset = 1'b0; flush = 1'b0; m_ready = 1'b1;
    wait_drain(60, "rand_drain");
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
